// File: rtl/branch_resolve_predict_if.sv
// Fetch-side prediction and execute-side resolution signals for the branch unit.
// The master drives PCs and operands; the slave returns the prediction and the registered results.
interface branch_resolve_predict_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic [XLEN-1:0]   pred_pc;
  logic              pred_taken;
  logic              ex_valid;
  logic [6:0]        ex_opcode;
  logic [2:0]        ex_br_type;
  logic [XLEN-1:0]   ex_rs1;
  logic [XLEN-1:0]   ex_rs2;
  logic [XLEN-1:0]   ex_pc;
  logic              ex_pred_taken;
  logic              br_taken;
  logic              mispredict;
  logic              illegal_br;
  logic [PERF_W-1:0] branch_cnt;
  logic [PERF_W-1:0] mispred_cnt;

  modport master (
    output pred_pc, ex_valid, ex_opcode, ex_br_type, ex_rs1, ex_rs2, ex_pc, ex_pred_taken,
    input  pred_taken, br_taken, mispredict, illegal_br, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pred_pc, ex_valid, ex_opcode, ex_br_type, ex_rs1, ex_rs2, ex_pc, ex_pred_taken,
    output pred_taken, br_taken, mispredict, illegal_br, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_predict.sv
// Branch resolution with a bimodal 2-bit-counter predictor and saturating perf counters.
// Prediction reads the table combinationally; training lands on the same edge as the results.
module branch_resolve_predict #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         INDEX_LSB   = 2,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         PERF_W      = 32
) (
  input logic                    clk,
  input logic                    reset,
  branch_resolve_predict_if.slave bus
);
  localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [1:0]        bht [BHT_ENTRIES];
  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  ex_idx;

  logic              is_b;
  logic              is_jal;
  logic              illegal_c;
  logic              legal_c;
  logic              taken_c;
  logic [1:0]        bht_cur;
  logic [1:0]        bht_next;

  logic              br_taken_q;
  logic              mispredict_q;
  logic              illegal_q;
  logic [PERF_W-1:0] branch_cnt_q;
  logic [PERF_W-1:0] mispred_cnt_q;

  assign pred_idx       = bus.pred_pc[INDEX_LSB +: IDX_W];
  assign ex_idx         = bus.ex_pc[INDEX_LSB +: IDX_W];
  assign bus.pred_taken = bht[pred_idx][1];

  always_comb begin
    is_b      = bus.ex_valid && (bus.ex_opcode == OP_B);
    is_jal    = bus.ex_valid && (bus.ex_opcode == OP_JAL);
    illegal_c = is_b && ((bus.ex_br_type == 3'd2) || (bus.ex_br_type == 3'd3));
    legal_c   = (is_b || is_jal) && !illegal_c;
    taken_c   = 1'b0;
    if (is_jal) begin
      taken_c = 1'b1;
    end else if (is_b) begin
      case (bus.ex_br_type)
        3'd0:    taken_c = (bus.ex_rs1 == bus.ex_rs2);
        3'd1:    taken_c = (bus.ex_rs1 != bus.ex_rs2);
        3'd4:    taken_c = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
        3'd5:    taken_c = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
        3'd6:    taken_c = (bus.ex_rs1 <  bus.ex_rs2);
        3'd7:    taken_c = (bus.ex_rs1 >= bus.ex_rs2);
        default: taken_c = 1'b0;
      endcase
    end
  end

  // Saturating step of the counter being trained
  always_comb begin
    bht_cur  = bht[ex_idx];
    bht_next = bht_cur;
    if (taken_c) begin
      if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_taken_q    <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
    end else begin
      br_taken_q   <= legal_c && taken_c;
      mispredict_q <= legal_c && (taken_c != bus.ex_pred_taken);
      illegal_q    <= illegal_c;
      if (legal_c && (branch_cnt_q != {PERF_W{1'b1}}))
        branch_cnt_q <= branch_cnt_q + PERF_W'(1);
      if (legal_c && (taken_c != bus.ex_pred_taken) && (mispred_cnt_q != {PERF_W{1'b1}}))
        mispred_cnt_q <= mispred_cnt_q + PERF_W'(1);
      if (legal_c && is_b)
        bht[ex_idx] <= bht_next;
    end
  end

  assign bus.br_taken    = br_taken_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.illegal_br  = illegal_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Bench for branch_resolve_predict: directed scenarios plus random traffic against a table model.
// A second instance with 4-bit perf counters shares the stimulus to exercise counter saturation.
module tb_branch_resolve_predict;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_predict_if #(.XLEN(32), .PERF_W(32)) bus ();
  branch_resolve_predict_if #(.XLEN(32), .PERF_W(4))  bus4 ();

  assign bus4.pred_pc       = bus.pred_pc;
  assign bus4.ex_valid      = bus.ex_valid;
  assign bus4.ex_opcode     = bus.ex_opcode;
  assign bus4.ex_br_type    = bus.ex_br_type;
  assign bus4.ex_rs1        = bus.ex_rs1;
  assign bus4.ex_rs2        = bus.ex_rs2;
  assign bus4.ex_pc         = bus.ex_pc;
  assign bus4.ex_pred_taken = bus.ex_pred_taken;

  branch_resolve_predict #(.PERF_W(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
  branch_resolve_predict #(.PERF_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: counters as plain integers 0..3, counts unbounded
  int      m_bht [64];
  longint  m_bcnt, m_mcnt;
  bit      exp_br, exp_mis, exp_ill;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic longint sat(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_bcnt = 0; m_mcnt = 0;
    exp_br = 0; exp_mis = 0; exp_ill = 0;
  endtask

  // One cycle: check results of the previous instruction, present a new one, check prediction
  task automatic step(input bit rst_n, input bit v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input bit pr, input logic [31:0] ppc);
    bit q, ill, leg, t;
    longint sa, sb;
    check_val("br_taken",    {63'd0, bus.br_taken},   {63'd0, exp_br});
    check_val("mispredict",  {63'd0, bus.mispredict}, {63'd0, exp_mis});
    check_val("illegal_br",  {63'd0, bus.illegal_br}, {63'd0, exp_ill});
    check_val("branch_cnt",  {32'd0, bus.branch_cnt},  64'(sat(m_bcnt, 64'hFFFF_FFFF)));
    check_val("mispred_cnt", {32'd0, bus.mispred_cnt}, 64'(sat(m_mcnt, 64'hFFFF_FFFF)));
    check_val("branch_cnt4", {60'd0, bus4.branch_cnt},  64'(sat(m_bcnt, 15)));
    check_val("mispred_cnt4",{60'd0, bus4.mispred_cnt}, 64'(sat(m_mcnt, 15)));
    reset = rst_n;
    bus.ex_valid = v; bus.ex_opcode = op; bus.ex_br_type = f3;
    bus.ex_rs1 = a; bus.ex_rs2 = b; bus.ex_pc = pc;
    bus.ex_pred_taken = pr; bus.pred_pc = ppc;
    #1;
    check_val("pred_taken", {63'd0, bus.pred_taken}, {63'd0, (m_bht[idx_of(ppc)] >= 2)});
    if (!rst_n) begin
      model_reset();
    end else begin
      q   = v && (op == OP_B || op == OP_JAL);
      ill = v && (op == OP_B) && (f3 == 3'd2 || f3 == 3'd3);
      leg = q && !ill;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      t   = 0;
      if (leg && op == OP_JAL) t = 1;
      else if (leg) begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = (sa < sb);
          3'd5: t = (sa >= sb);
          3'd6: t = (longint'(a) < longint'(b));
          default: t = (longint'(a) >= longint'(b));
        endcase
      end
      exp_br  = leg && t;
      exp_mis = leg && (t != pr);
      exp_ill = ill;
      if (leg) m_bcnt++;
      if (exp_mis) m_mcnt++;
      if (leg && op == OP_B) begin
        if (t && m_bht[idx_of(pc)] < 3) m_bht[idx_of(pc)]++;
        if (!t && m_bht[idx_of(pc)] > 0) m_bht[idx_of(pc)]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic bubble(input logic [31:0] ppc);
    step(1, 0, OP_ALU, 3'd0, 0, 0, 0, 0, ppc);
  endtask

  task automatic peek_pred(input string tag, input logic [31:0] ppc, input bit exp);
    bus.pred_pc = ppc;
    #1;
    check_val(tag, {63'd0, bus.pred_taken}, {63'd0, exp});
  endtask

  initial begin
    logic [31:0] a, b, pc, ppc;
    logic [6:0]  op;
    int          r;
    bus.pred_pc = 0; bus.ex_valid = 0; bus.ex_opcode = 0; bus.ex_br_type = 0;
    bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_pc = 0; bus.ex_pred_taken = 0;
    reset = 0;
    model_reset();
    @(posedge clk); @(negedge clk);
    bubble(32'h40);

    // BEQ equal operands, predicted not-taken
    step(1, 1, OP_B, 3'd0, 5, 5, 32'h40, 0, 32'h40);
    check_val("tp_beq_taken", {63'd0, bus.br_taken}, 64'd1);
    check_val("tp_beq_mis",   {63'd0, bus.mispredict}, 64'd1);
    check_val("tp_beq_cnt",   {32'd0, bus.branch_cnt}, 64'd1);
    peek_pred("tp_beq_pred", 32'h40, 1);

    // Signed vs unsigned on 0xFFFFFFFF vs 1
    step(1, 1, OP_B, 3'd4, 32'hFFFF_FFFF, 1, 32'h200, 0, 0);
    check_val("tp_blt", {63'd0, bus.br_taken}, 64'd1);
    step(1, 1, OP_B, 3'd6, 32'hFFFF_FFFF, 1, 32'h200, 0, 0);
    check_val("tp_bltu", {63'd0, bus.br_taken}, 64'd0);
    step(1, 1, OP_B, 3'd7, 32'hFFFF_FFFF, 1, 32'h200, 0, 0);
    check_val("tp_bgeu", {63'd0, bus.br_taken}, 64'd1);

    // Saturation at pc 0x80
    for (int i = 0; i < 4; i++) step(1, 1, OP_B, 3'd1, 1, 2, 32'h80, 1, 32'h80);
    step(1, 1, OP_B, 3'd1, 7, 7, 32'h80, 1, 32'h80);
    peek_pred("tp_sat_hold", 32'h80, 1);
    for (int i = 0; i < 3; i++) step(1, 1, OP_B, 3'd1, 7, 7, 32'h80, 1, 32'h80);
    peek_pred("tp_sat_low", 32'h80, 0);

    // JAL and illegal funct3
    step(1, 1, OP_JAL, 3'd0, 0, 0, 32'h80, 0, 32'h80);
    check_val("tp_jal_taken", {63'd0, bus.br_taken}, 64'd1);
    check_val("tp_jal_mis",   {63'd0, bus.mispredict}, 64'd1);
    peek_pred("tp_jal_bht", 32'h80, 0);
    step(1, 1, OP_B, 3'd2, 3, 3, 32'h44, 1, 32'h44);
    check_val("tp_ill_flag",  {63'd0, bus.illegal_br}, 64'd1);
    check_val("tp_ill_taken", {63'd0, bus.br_taken}, 64'd0);
    check_val("tp_ill_mis",   {63'd0, bus.mispredict}, 64'd0);

    // Mid-stream reset with an instruction in the reset cycle
    step(0, 1, OP_B, 3'd0, 1, 1, 32'h40, 0, 32'h40);
    check_val("tp_rst_cnt", {32'd0, bus.branch_cnt}, 64'd0);
    check_val("tp_rst_br",  {63'd0, bus.br_taken}, 64'd0);
    peek_pred("tp_rst_bht", 32'h40, 0);

    // Collision: predict and train the same index in one cycle
    step(1, 1, OP_B, 3'd0, 9, 9, 32'h100, 0, 32'h100);
    peek_pred("tp_coll_after", 32'h100, 1);

    // Perf counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) step(1, 1, OP_JAL, 3'd0, 0, 0, 32'h10, 0, 0);
    check_val("tp_sat4_mis", {60'd0, bus4.mispred_cnt}, 64'd15);
    check_val("tp_sat4_br",  {60'd0, bus4.branch_cnt}, 64'd15);

    // Random traffic over a small PC window so indices collide often
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 6) ? OP_B : (r < 8) ? OP_JAL : OP_ALU;
      pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      ppc = ($urandom_range(0, 3) == 0) ? pc : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = ~a;
        2: b = a + 32'($urandom_range(0, 2)) - 32'd1;
        default: b = $urandom;
      endcase
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0), op,
           3'($urandom_range(0, 7)), a, b, pc, 1'($urandom_range(0, 1)), ppc);
    end
    bubble(0);
    bubble(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
